// File: rtl/instruction_fetch_if.sv
// Bundle of the fetch stage's instruction-memory and decode-side signals.
//   master : the fetch stage (drives imem_req/imem_addr and the decode outputs)
//   slave  : the environment (memory returns imem_ack/imem_rdata, decode/execute
//            drive stall, redirect and redirect_pc)
// Memory handshake: imem_req/imem_addr are held stable from the cycle imem_req
// rises until the cycle imem_ack is high. imem_rdata is only meaningful while
// imem_ack is high, and that same cycle completes the request.
interface instruction_fetch_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [23:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [23:0] instruction;
  logic [15:0] pc_out;
  logic        valid;

  modport master (
    output imem_req, imem_addr, instruction, pc_out, valid,
    input  imem_ack, imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instruction, pc_out, valid,
    output imem_ack, imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch front end. Owns the PC, issues word reads to instruction
// memory, buffers returned {pc, instruction} pairs in a small FIFO and presents
// the FIFO head to decode. Redirects flush the buffer and restart fetch; a read
// already in flight at redirect time is drained and its data dropped (DISCARD).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : instruction_fetch_if.master (memory req/ack, decode outputs,
//                 stall, redirect, redirect_pc)
//   state_dbg   : 1 while in DISCARD, 0 in FETCH
module instruction_fetch #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [23:0] NOP_INSTR  = 24'h000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  instruction_fetch_if.master        bus,
  output logic                       state_dbg
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic {S_FETCH = 1'b0, S_DISCARD = 1'b1} state_t;

  state_t           state;
  logic [15:0]      pc;
  logic [15:0]      req_addr;
  logic             req;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [15:0]      fifo_pc    [FIFO_DEPTH];
  logic [23:0]      fifo_instr [FIFO_DEPTH];

  logic             push;
  logic             pop;
  logic             has_data;
  logic [CNT_W-1:0] count_n;
  logic [15:0]      pc_n;

  // Redirect overrides push and pop: whatever arrives or would be consumed in
  // the redirect cycle belongs to the abandoned path.
  always_comb begin
    has_data = (count != '0);
    push     = (state == S_FETCH) && req && bus.imem_ack && !bus.redirect;
    pop      = has_data && !bus.stall && !bus.redirect;
    count_n  = count;
    if (push && !pop)
      count_n = count + CNT_W'(1);
    else if (!push && pop)
      count_n = count - CNT_W'(1);
    pc_n = push ? pc + 16'd1 : pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      req      <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (bus.redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            pc     <= bus.redirect_pc;
            if (req && !bus.imem_ack) begin
              // Old read still in flight: keep it alive until acked, then drop it.
              state <= S_DISCARD;
            end else begin
              req      <= 1'b1;
              req_addr <= bus.redirect_pc;
            end
          end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_n;
            pc    <= pc_n;
            // A new request is only issued if the entry it will fill is free
            // after this edge; count cannot rise while it is outstanding.
            if (!req || bus.imem_ack) begin
              req      <= (count_n < FULL);
              req_addr <= pc_n;
            end
          end
        end
        S_DISCARD: begin
          if (bus.redirect) pc <= bus.redirect_pc;
          if (bus.imem_ack) begin
            state    <= S_FETCH;
            req      <= 1'b1;
            req_addr <= bus.redirect ? bus.redirect_pc : pc;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  // Buffer storage needs no reset: entries are only read while count says valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= req_addr;
      fifo_instr[wr_ptr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = req_addr;
  assign bus.valid       = has_data;
  assign bus.instruction = has_data ? fifo_instr[rd_ptr] : NOP_INSTR;
  assign bus.pc_out      = has_data ? fifo_pc[rd_ptr] : 16'h0000;
  assign state_dbg       = (state == S_DISCARD);
endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  logic clk;
  logic rst_n;
  logic state_dbg;

  instruction_fetch_if ifc ();

  instruction_fetch #(
    .RESET_PC   (16'h0000),
    .FIFO_DEPTH (2),
    .NOP_INSTR  (24'h000000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifc.master),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  // Word at address a is 24'hA00001 + a. Ack comes after mem_lat waiting cycles.
  int mem_lat  = 0;
  int wait_cnt = 0;
  int ack_cnt  = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      wait_cnt       = 0;
      ifc.imem_ack   = 1'b0;
      ifc.imem_rdata = '0;
    end else if (ifc.imem_req && wait_cnt >= mem_lat) begin
      ifc.imem_ack   = 1'b1;
      ifc.imem_rdata = 24'hA00001 + {8'h00, ifc.imem_addr};
      wait_cnt       = 0;
      ack_cnt        = ack_cnt + 1;
    end else begin
      ifc.imem_ack   = 1'b0;
      ifc.imem_rdata = '0;
      if (ifc.imem_req) wait_cnt = wait_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [23:0] ins,
                         input logic [15:0] pco);
    chk({tag, ".valid"}, ifc.valid, v);
    chk({tag, ".instr"}, ifc.instruction, ins);
    chk({tag, ".pc_out"}, ifc.pc_out, pco);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int acks0;
    logic [15:0] e;
    rst_n           = 1'b0;
    ifc.stall       = 1'b0;
    ifc.redirect    = 1'b0;
    ifc.redirect_pc = 16'h0000;
    step();
    step();

    // Reset values
    chk_out("reset", 1'b0, 24'h000000, 16'h0000);
    chk("reset.req", ifc.imem_req, 1'b0);
    chk("reset.addr", ifc.imem_addr, 16'h0000);
    chk("reset.state", state_dbg, 1'b0);

    // Test 1: single-cycle memory, sequential stream
    rst_n = 1'b1;
    step();
    chk("t1.req", ifc.imem_req, 1'b1);
    chk("t1.addr0", ifc.imem_addr, 16'h0000);
    chk("t1.valid0", ifc.valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_out("t1.head", 1'b1, 24'hA00001 + 24'(k), 16'(k));
      chk("t1.addr", ifc.imem_addr, 16'(k + 1));
    end

    // Test 5: redirect in the ack cycle with stall high; both the held entry
    // and the arriving word are dropped.
    ifc.stall       = 1'b1;
    ifc.redirect    = 1'b1;
    ifc.redirect_pc = 16'h0010;
    step();
    ifc.redirect = 1'b0;
    chk_out("t5.flush", 1'b0, 24'h000000, 16'h0000);
    chk("t5.req", ifc.imem_req, 1'b1);
    chk("t5.addr", ifc.imem_addr, 16'h0010);

    // Test 2: stall for 5 cycles from empty -> exactly two acks, head held
    acks0 = ack_cnt;
    step();
    chk_out("t2.first", 1'b1, 24'hA00011, 16'h0010);
    step();
    chk("t2.req_low", ifc.imem_req, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out("t2.hold", 1'b1, 24'hA00011, 16'h0010);
      chk("t2.req_hold", ifc.imem_req, 1'b0);
    end
    chk("t2.acks", 32'(ack_cnt - acks0), 32'd2);
    ifc.stall = 1'b0;
    for (int k = 0; k < 4; k++) exp_q.push_back(16'h0011 + 16'(k));
    while (exp_q.size() != 0) begin
      step();
      e = exp_q.pop_front();
      chk_out("t2.drain", 1'b1, 24'hA00001 + {8'h00, e}, e);
    end
    chk("t2.addr", ifc.imem_addr, 16'h0015);

    // Test 3: memory with 2 wait cycles
    mem_lat = 2;
    step();
    chk("t3.valid1", ifc.valid, 1'b0);
    chk("t3.addr1", ifc.imem_addr, 16'h0015);
    step();
    chk("t3.valid2", ifc.valid, 1'b0);
    chk("t3.addr2", ifc.imem_addr, 16'h0015);
    chk("t3.req2", ifc.imem_req, 1'b1);
    step();
    chk_out("t3.got", 1'b1, 24'hA00016, 16'h0015);
    chk("t3.addr3", ifc.imem_addr, 16'h0016);
    step();
    chk("t3.valid4", ifc.valid, 1'b0);
    chk("t3.addr4", ifc.imem_addr, 16'h0016);

    // Test 4: redirect with a read outstanding -> DISCARD
    ifc.redirect    = 1'b1;
    ifc.redirect_pc = 16'h0040;
    step();
    ifc.redirect = 1'b0;
    chk("t4.state", state_dbg, 1'b1);
    chk("t4.addr_old", ifc.imem_addr, 16'h0016);
    chk("t4.req", ifc.imem_req, 1'b1);
    chk("t4.valid", ifc.valid, 1'b0);
    step();
    mem_lat = 0;
    chk("t4.state_back", state_dbg, 1'b0);
    chk("t4.addr_new", ifc.imem_addr, 16'h0040);
    chk("t4.valid_drop", ifc.valid, 1'b0);
    step();
    chk_out("t4.resume", 1'b1, 24'hA00041, 16'h0040);

    // Test 6: PC wrap after redirect to FFFF, then mid-stream reset
    ifc.redirect    = 1'b1;
    ifc.redirect_pc = 16'hFFFF;
    step();
    ifc.redirect = 1'b0;
    chk("t6.valid", ifc.valid, 1'b0);
    chk("t6.addr_ffff", ifc.imem_addr, 16'hFFFF);
    step();
    chk_out("t6.head_ffff", 1'b1, 24'hA10000, 16'hFFFF);
    chk("t6.addr_wrap", ifc.imem_addr, 16'h0000);
    step();
    chk_out("t6.head_0", 1'b1, 24'hA00001, 16'h0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("t6.rst", 1'b0, 24'h000000, 16'h0000);
    chk("t6.rst_req", ifc.imem_req, 1'b0);
    chk("t6.rst_addr", ifc.imem_addr, 16'h0000);
    step();
    rst_n = 1'b1;
    step();
    chk("t6.restart_addr", ifc.imem_addr, 16'h0000);
    step();
    chk_out("t6.restart", 1'b1, 24'hA00001, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
